// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave register bank.
// The debug struct exposes FSM state, bit counter and latched frame mode.
package spi_slave_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 7;
  localparam int ADDR_BITS  = 7;
  localparam int BIT_CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    DRAIN,
    ERR
  } state_t;

  typedef struct packed {
    state_t                 state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   mode;
    logic                   cs_active;
  } dbg_t;

  function automatic logic addr_mapped(input logic [7:0] a, input int n);
    return int'({24'd0, a}) < n;
  endfunction

endpackage

// File: rtl/spi_slave_regbank_if.sv
// Pin and host-port bundle for spi_slave_regbank.
interface spi_slave_regbank_if;

  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       mode;
  logic [7:0] reg_addr;
  logic       reg_write;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       ready;

  // Host handshake: reg_write is taken only on a clk edge where ready is high;
  // a write presented while ready is low is dropped, not held or retried.
  // reg_rdata always reflects regs[reg_addr] from the previous edge.
  modport master (
    output cs_n, sclk, mosi, mode, reg_addr, reg_write, reg_wdata,
    input  miso, reg_rdata, ready
  );

  modport slave (
    input  cs_n, sclk, mosi, mode, reg_addr, reg_write, reg_wdata,
    output miso, reg_rdata, ready
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave (mode 0/3, 16-bit frames) owning a byte register bank shared with a host port.
// Define SPI_SLAVE_AUTOINC_EN for unbounded address-incrementing bursts.
module spi_slave_regbank
  import spi_slave_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_slave_regbank_if.slave bus,
  output dbg_t               dbg
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_W-2:0]      shift_in;
  logic [DATA_W-1:0]      shift_out;
  logic                   rw_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   mode_q;
  logic                   miso_q;
  logic                   ready_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [DATA_W-1:0]      regs [NUM_REGS];

  logic [DATA_W-1:0] rx_byte;
  logic              byte_done;
  logic              spi_we;
  logic              host_we;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (bus.sclk),
    .level    (sclk_s),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (bus.cs_n),
    .level    (cs_s),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi shares the sclk synchroniser depth so data and clock stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mosi_sync <= '0;
    else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  function automatic logic [DATA_W-1:0] reg_read(input logic [7:0] a);
    logic [IDX_W-1:0] idx;
    idx = a[IDX_W-1:0];
    if (addr_mapped(a, NUM_REGS)) return regs[idx];
    return '0;
  endfunction

  assign rx_byte   = {shift_in, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign spi_we    = (state == DATA) && byte_done && rw_q &&
                     addr_mapped({1'b0, addr_q}, NUM_REGS);
  assign host_we   = bus.reg_write && ready_q && addr_mapped(bus.reg_addr, NUM_REGS);

`ifdef SPI_SLAVE_AUTOINC_EN
  logic [ADDR_BITS-1:0] addr_inc;
  assign addr_inc = ADDR_BITS'((32'(addr_q) + 1) % NUM_REGS);
`endif

  // SPI commits happen only outside IDLE, host writes only in IDLE: never both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (spi_we) begin
      regs[addr_q[IDX_W-1:0]] <= rx_byte;
    end else if (host_we) begin
      regs[bus.reg_addr[IDX_W-1:0]] <= bus.reg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= reg_read(bus.reg_addr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      mode_q    <= 1'b0;
      miso_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else if (cs_rise) begin
      state   <= IDLE;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            ready_q <= 1'b0;
            bit_cnt <= '0;
            mode_q  <= bus.mode;
            state   <= (sclk_s == bus.mode) ? CMD : ERR;
          end
        end
        CMD: begin
          miso_q <= 1'b0;
          if (sclk_rise) begin
            shift_in <= rx_byte[DATA_W-2:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw_q      <= rx_byte[RW_BIT];
              addr_q    <= rx_byte[ADDR_BITS-1:0];
              shift_out <= rx_byte[RW_BIT] ? '0 : reg_read({1'b0, rx_byte[ADDR_BITS-1:0]});
              state     <= DATA;
            end
          end
        end
        DATA: begin
          if (sclk_fall) begin
            miso_q    <= shift_out[DATA_W-1];
            shift_out <= {shift_out[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            shift_in <= rx_byte[DATA_W-2:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef SPI_SLAVE_AUTOINC_EN
              addr_q <= addr_inc;
              if (!rw_q) shift_out <= reg_read({1'b0, addr_inc});
`else
              state  <= DRAIN;
              miso_q <= 1'b0;
`endif
            end
          end
        end
        DRAIN: miso_q <= 1'b0;
        ERR:   miso_q <= 1'b0;
        default: begin
          state  <= IDLE;
          miso_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miso      = miso_q;
  assign bus.ready     = ready_q;
  assign bus.reg_rdata = rdata_q;

  assign dbg = '{state: state, bit_cnt: bit_cnt, mode: mode_q, cs_active: ~cs_s};

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench for spi_slave_regbank: mode 0/3 frames, abort, idle mismatch,
// host gating, unmapped addresses, bursts and reset mid-frame.
module tb_spi_slave_regbank;
  import spi_slave_pkg::*;

  localparam int HALF = 6;

  logic clk;
  logic reset_n;
  dbg_t dbg;

  spi_slave_regbank_if bus ();

  spi_slave_regbank #(.NUM_REGS(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .dbg     (dbg)
  );

  int checks;
  int failures;
  logic       cur_mode;
  logic [7:0] exp_regs [16];
  logic [7:0] exp_q [$];
  logic [7:0] mb0, mb1, mb2;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin(input logic m);
    cur_mode = m;
    bus.mode = m;
    bus.sclk = m;
    bus.mosi = 1'b0;
    wait_clk(4);
    bus.cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_bit(input logic b, output logic o);
    if (cur_mode) bus.sclk = 1'b0;
    bus.mosi = b;
    wait_clk(HALF);
    bus.sclk = 1'b1;
    o = bus.miso;
    wait_clk(HALF);
    if (!cur_mode) bus.sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] rx);
    logic o;
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], o);
      rx = {rx[6:0], o};
    end
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    bus.cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_write = 1'b1;
    wait_clk(1);
    bus.reg_write = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    bus.reg_addr = a;
    wait_clk(1);
    d = bus.reg_rdata;
  endtask

  // scenarios
  task automatic test_reset();
    logic [7:0] d;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
    checks++; if (bus.reg_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h expected 00", bus.reg_rdata); end
    checks++; if (dbg.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg.state, IDLE); end
    host_read(8'd3, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg3: got %h expected 00", d); end
  endtask

  task automatic test_mode0_write();
    spi_begin(1'b0);
    spi_byte(8'h83, mb0);
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL m0w_ready_mid: got %b expected 0", bus.ready); end
    spi_byte(8'h5A, mb1);
    spi_end();
    exp_regs[3] = 8'h5A;
    checks++; if (mb0 !== 8'h00) begin failures++; $display("FAIL m0w_miso_cmd: got %h expected 00", mb0); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL m0w_ready_after: got %b expected 1", bus.ready); end
    bus.reg_addr = 8'd3;
    wait_clk(1);
    checks++; if (bus.reg_rdata !== exp_regs[3]) begin failures++; $display("FAIL m0w_rdata: got %h expected %h", bus.reg_rdata, exp_regs[3]); end
  endtask

  task automatic test_mode3_read();
    spi_begin(1'b1);
    spi_byte(8'h03, mb0);
    checks++; if (dbg.mode !== 1'b1) begin failures++; $display("FAIL m3r_mode: got %b expected 1", dbg.mode); end
    spi_byte(8'h00, mb1);
    spi_end();
    checks++; if (mb0 !== 8'h00) begin failures++; $display("FAIL m3r_miso_cmd: got %h expected 00", mb0); end
    checks++; if (mb1 !== 8'h5A) begin failures++; $display("FAIL m3r_miso_data: got %h expected 5a", mb1); end
  endtask

  task automatic test_abort();
    logic o;
    logic [7:0] d;
    spi_begin(1'b0);
    spi_byte(8'h85, mb0);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, o);
    spi_end();
    checks++; if (dbg.state !== IDLE) begin failures++; $display("FAIL abort_state: got %0d expected %0d", dbg.state, IDLE); end
    checks++; if (dbg.bit_cnt !== 3'd0) begin failures++; $display("FAIL abort_bitcnt: got %0d expected 0", dbg.bit_cnt); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", bus.ready); end
    host_read(8'd5, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL abort_reg5: got %h expected 00", d); end
  endtask

  task automatic test_idle_mismatch();
    logic [7:0] d;
    cur_mode = 1'b1;
    bus.mode = 1'b1;
    bus.sclk = 1'b0;
    wait_clk(4);
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    checks++; if (dbg.state !== ERR) begin failures++; $display("FAIL mism_state: got %0d expected %0d", dbg.state, ERR); end
    spi_byte(8'h84, mb0);
    spi_byte(8'h11, mb1);
    checks++; if (dbg.state !== ERR) begin failures++; $display("FAIL mism_state_end: got %0d expected %0d", dbg.state, ERR); end
    checks++; if ({mb0, mb1} !== 16'h0000) begin failures++; $display("FAIL mism_miso: got %h expected 0000", {mb0, mb1}); end
    spi_end();
    host_read(8'd4, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mism_reg4: got %h expected 00", d); end
  endtask

  task automatic test_host_gating();
    logic [7:0] d;
    spi_begin(1'b0);
    spi_byte(8'h02, mb0);
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL gate_ready: got %b expected 0", bus.ready); end
    host_write(8'd2, 8'h77);
    spi_byte(8'h00, mb1);
    spi_end();
    host_read(8'd2, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL gate_blocked: got %h expected 00", d); end
    host_write(8'd2, 8'h77);
    exp_regs[2] = 8'h77;
    checks++; if (bus.reg_rdata !== 8'h00) begin failures++; $display("FAIL gate_rdata_old: got %h expected 00", bus.reg_rdata); end
    wait_clk(1);
    checks++; if (bus.reg_rdata !== 8'h77) begin failures++; $display("FAIL gate_rdata_new: got %h expected 77", bus.reg_rdata); end
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    spi_begin(1'b0);
    spi_byte(8'h7F, mb0);
    spi_byte(8'h00, mb1);
    spi_end();
    checks++; if (mb1 !== 8'h00) begin failures++; $display("FAIL unmap_read: got %h expected 00", mb1); end
    spi_begin(1'b1);
    spi_byte(8'hFF, mb0);
    spi_byte(8'hAA, mb1);
    spi_end();
    host_read(8'h7F, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL unmap_host: got %h expected 00", d); end
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_regs[i]);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      host_read(8'(i), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL unmap_sweep[%0d]: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    spi_begin(1'b0);
    spi_byte(8'h81, mb0);
    spi_byte(8'h11, mb1);
    spi_end();
    spi_begin(1'b0);
    spi_byte(8'h82, mb0);
    spi_byte(8'h22, mb1);
    spi_end();
    exp_regs[1] = 8'h11;
    exp_regs[2] = 8'h22;
    spi_begin(1'b1);
    spi_byte(8'h01, mb0);
    spi_byte(8'h00, mb1);
    spi_end();
    checks++; if (mb1 !== 8'h11) begin failures++; $display("FAIL b2b_read1: got %h expected 11", mb1); end
    host_read(8'd2, d);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL b2b_reg2: got %h expected 22", d); end
  endtask

  task automatic test_burst();
    logic [7:0] d;
    logic [7:0] exp_r0;
`ifdef SPI_SLAVE_AUTOINC_EN
    exp_r0 = 8'h02;
`else
    exp_r0 = 8'h00;
`endif
    spi_begin(1'b0);
    spi_byte(8'h8F, mb0);
    spi_byte(8'h01, mb1);
    spi_byte(8'h02, mb2);
    spi_end();
    exp_regs[15] = 8'h01;
    exp_regs[0]  = exp_r0;
    host_read(8'd15, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL burst_reg15: got %h expected 01", d); end
    host_read(8'd0, d);
    checks++; if (d !== exp_r0) begin failures++; $display("FAIL burst_reg0: got %h expected %h", d, exp_r0); end
    spi_begin(1'b0);
    spi_byte(8'h0F, mb0);
    spi_byte(8'h00, mb1);
    spi_byte(8'h00, mb2);
    spi_end();
    checks++; if (mb1 !== 8'h01) begin failures++; $display("FAIL burst_rd1: got %h expected 01", mb1); end
    checks++; if (mb2 !== exp_r0) begin failures++; $display("FAIL burst_rd2: got %h expected %h", mb2, exp_r0); end
  endtask

  task automatic test_reset_mid_frame();
    logic o;
    logic [7:0] d;
    spi_begin(1'b0);
    spi_byte(8'h86, mb0);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, o);
    reset_n   = 1'b0;
    bus.cs_n  = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b expected 1", bus.ready); end
    checks++; if (dbg.state !== IDLE) begin failures++; $display("FAIL rstmid_state: got %0d expected %0d", dbg.state, IDLE); end
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(6);
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_regs[i]);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      host_read(8'(i), d);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL rstmid_sweep[%0d]: got %h expected %h", i, d, e); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cur_mode = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    reset_n       = 1'b0;
    bus.cs_n      = 1'b1;
    bus.sclk      = 1'b0;
    bus.mosi      = 1'b0;
    bus.mode      = 1'b0;
    bus.reg_addr  = 8'h00;
    bus.reg_write = 1'b0;
    bus.reg_wdata = 8'h00;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(4);

    test_reset();
    test_mode0_write();
    test_mode3_read();
    test_abort();
    test_idle_mismatch();
    test_host_gating();
    test_unmapped();
    test_back_to_back();
    test_burst();
    test_reset_mid_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
